// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter that funnels NumMasters AXI read masters onto one
// downstream AXI read port, keeping at most one transaction outstanding.
//
// Optional build macro AXI_RD_ARB_DECERR_EN: when defined, a decode error on the granted
// address is answered locally (ERR state) with SLVERR-free DECERR beats instead of being
// forwarded downstream.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   m_arvalid_i/m_arready_o           per-master AR handshake
//   m_araddr_i, m_arlen_i             per-master AR payload, master k at slice k
//   m_rvalid_o/m_rready_i             per-master R handshake
//   m_rdata_o, m_rresp_o, m_rlast_o   shared R payload
//   s_ar*                             downstream AR channel
//   s_r*                              downstream R channel
//   dec_error_i                       combinational decode error for s_araddr_o
//   grant_o                           current owner
//   busy_o                            high whenever not idle
module axi_rd_arbiter #(
   parameter int unsigned NumMasters = 2,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 32,
   localparam int unsigned SelWidth  = $clog2(NumMasters)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumMasters-1:0]           m_arvalid_i,
   output logic [NumMasters-1:0]           m_arready_o,
   input  logic [NumMasters*AddrWidth-1:0] m_araddr_i,
   input  logic [NumMasters*8-1:0]         m_arlen_i,
   output logic [NumMasters-1:0]           m_rvalid_o,
   input  logic [NumMasters-1:0]           m_rready_i,
   output logic [DataWidth-1:0]            m_rdata_o,
   output logic [1:0]                      m_rresp_o,
   output logic                            m_rlast_o,
   output logic                            s_arvalid_o,
   input  logic                            s_arready_i,
   output logic [AddrWidth-1:0]            s_araddr_o,
   output logic [7:0]                      s_arlen_o,
   input  logic                            s_rvalid_i,
   output logic                            s_rready_o,
   input  logic [DataWidth-1:0]            s_rdata_i,
   input  logic [1:0]                      s_rresp_i,
   input  logic                            s_rlast_i,
   input  logic                            dec_error_i,
   output logic [SelWidth-1:0]             grant_o,
   output logic                            busy_o
);

`ifdef AXI_RD_ARB_DECERR_EN
   typedef enum logic [1:0] {StIdle, StAddr, StData, StErr} state_e;
`else
   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
`endif

   state_e              state_q, state_d;
   logic [SelWidth-1:0] grant_q, grant_d;
   logic [SelWidth-1:0] last_grant_q, last_grant_d;

`ifdef AXI_RD_ARB_DECERR_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
`else
   logic unused_dec_error;
   assign unused_dec_error = dec_error_i;
`endif

   // Granted master's request fields and R-ready.
   logic [NumMasters-1:0] grant_oh;
   logic [AddrWidth-1:0]  sel_addr;
   logic [7:0]            sel_len;
   logic                  sel_rready;

   always_comb begin
      grant_oh   = '0;
      sel_addr   = '0;
      sel_len    = '0;
      sel_rready = 1'b0;
      for (int unsigned k = 0; k < NumMasters; k++) begin
         if (grant_q == SelWidth'(k)) begin
            grant_oh[k] = 1'b1;
            sel_addr    = m_araddr_i[k*AddrWidth +: AddrWidth];
            sel_len     = m_arlen_i[k*8 +: 8];
            sel_rready  = m_rready_i[k];
         end
      end
   end

   // Round-robin search starting at last_grant+1; first requester found wins.
   logic                rr_found;
   logic [SelWidth-1:0] rr_pick;

   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      for (int unsigned i = 1; i <= NumMasters; i++) begin
         for (int unsigned k = 0; k < NumMasters; k++) begin
            if (!rr_found && m_arvalid_i[k] &&
                k == (32'(last_grant_q) + i) % NumMasters) begin
               rr_found = 1'b1;
               rr_pick  = SelWidth'(k);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= SelWidth'(NumMasters - 1);
`ifdef AXI_RD_ARB_DECERR_EN
         beat_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
`ifdef AXI_RD_ARB_DECERR_EN
         beat_cnt_q   <= beat_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
`ifdef AXI_RD_ARB_DECERR_EN
      beat_cnt_d   = beat_cnt_q;
`endif
      m_arready_o  = '0;
      m_rvalid_o   = '0;
      m_rdata_o    = '0;
      m_rresp_o    = '0;
      m_rlast_o    = 1'b0;
      s_arvalid_o  = 1'b0;
      s_araddr_o   = '0;
      s_arlen_o    = '0;
      s_rready_o   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rr_found) begin
               grant_d = rr_pick;
               state_d = StAddr;
            end
         end

         StAddr: begin
            // Address is presented even on a decode error: the decoder looks at it.
            s_araddr_o = sel_addr;
            s_arlen_o  = sel_len;
`ifdef AXI_RD_ARB_DECERR_EN
            if (dec_error_i) begin
               m_arready_o = grant_oh;
               beat_cnt_d  = sel_len;
               state_d     = StErr;
            end else begin
               s_arvalid_o = 1'b1;
               m_arready_o = grant_oh & {NumMasters{s_arready_i}};
               if (s_arready_i) state_d = StData;
            end
`else
            s_arvalid_o = 1'b1;
            m_arready_o = grant_oh & {NumMasters{s_arready_i}};
            if (s_arready_i) state_d = StData;
`endif
         end

         StData: begin
            m_rvalid_o = grant_oh & {NumMasters{s_rvalid_i}};
            m_rdata_o  = s_rdata_i;
            m_rresp_o  = s_rresp_i;
            m_rlast_o  = s_rlast_i;
            s_rready_o = sel_rready;
            if (s_rvalid_i && sel_rready && s_rlast_i) begin
               last_grant_d = grant_q;
               state_d      = StIdle;
            end
         end

`ifdef AXI_RD_ARB_DECERR_EN
         StErr: begin
            m_rvalid_o = grant_oh;
            m_rresp_o  = 2'b11;
            m_rlast_o  = (beat_cnt_q == 8'd0);
            if (sel_rready) begin
               if (beat_cnt_q == 8'd0) begin
                  last_grant_d = grant_q;
                  state_d      = StIdle;
               end else begin
                  beat_cnt_d = beat_cnt_q - 8'd1;
               end
            end
         end
`endif

         default: state_d = StIdle;
      endcase
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter (NumMasters=2, 32-bit address/data). The main
// process drives masters and a simple downstream slave and pushes expectations; the
// monitor process pops and compares on every AR/R handshake and on status snapshots.
module tb_axi_rd_arbiter;
   localparam int unsigned NM = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [NM-1:0]    m_arvalid_i;
   logic [NM-1:0]    m_arready_o;
   logic [NM*AW-1:0] m_araddr_i;
   logic [NM*8-1:0]  m_arlen_i;
   logic [NM-1:0]    m_rvalid_o;
   logic [NM-1:0]    m_rready_i;
   logic [DW-1:0]    m_rdata_o;
   logic [1:0]       m_rresp_o;
   logic             m_rlast_o;
   logic             s_arvalid_o;
   logic             s_arready_i;
   logic [AW-1:0]    s_araddr_o;
   logic [7:0]       s_arlen_o;
   logic             s_rvalid_i;
   logic             s_rready_o;
   logic [DW-1:0]    s_rdata_i;
   logic [1:0]       s_rresp_i;
   logic             s_rlast_i;
   logic             dec_error_i;
   logic             grant_o;
   logic             busy_o;

   always #5 clk_i = ~clk_i;

   // Region 0x0003_xxxx is unmapped.
   assign dec_error_i = (s_araddr_o[31:16] == 16'h0003);

   axi_rd_arbiter #(.NumMasters(NM), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
      .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
      .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
      .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o),
      .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
      .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
      .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
      .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i),
      .dec_error_i(dec_error_i), .grant_o(grant_o), .busy_o(busy_o)
   );

   typedef struct {int master; logic [31:0] addr; logic [7:0] len;} ar_exp_t;
   typedef struct {int master; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
   typedef struct {
      logic busy; logic sarv; logic [31:0] saddr; logic [1:0] mar;
      logic [1:0] mrv; logic srr; logic grant; logic [31:0] rdata;
   } st_exp_t;

   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];
   st_exp_t st_q[$];

   int   checks = 0;
   int   errors = 0;
   logic done = 1'b0;

   // Slave model state and per-step observations (main process only).
   logic [31:0] sl_addr;
   logic [7:0]  sl_len;
   int          sl_beat;
   int          ar_hold;
   logic        rr_toggle;
   logic        m0_cont;
   int          m0_grants;
   logic        n_sarv, n_rhs, n_last_hs;

   function automatic logic [1:0] onehot(int k);
      logic [1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endfunction

   task automatic expect_txn(int k, logic [31:0] addr, logic [7:0] len, int nbeats);
      ar_q.push_back('{k, addr, len});
      for (int b = 0; b < nbeats; b++)
         r_q.push_back('{k, addr + 32'(b), 2'(b), (b == int'(len))});
   endtask

   task automatic expect_err(int k, logic [7:0] len);
      for (int b = 0; b <= int'(len); b++) r_q.push_back('{k, 32'h0, 2'b11, (b == int'(len))});
   endtask

   task automatic expect_st(logic busy, logic sarv, logic [31:0] saddr, logic [1:0] mar,
                            logic [1:0] mrv, logic srr, logic grant, logic [31:0] rdata);
      st_q.push_back('{busy, sarv, saddr, mar, mrv, srr, grant, rdata});
   endtask

   task automatic issue(int k, logic [31:0] addr, logic [7:0] len);
      m_araddr_i[k*AW +: AW] = addr;
      m_arlen_i[k*8 +: 8]    = len;
      m_arvalid_i[k]         = 1'b1;
   endtask

   task automatic timeout(string name);
      $display("FAIL %s act=timeout exp=progress", name);
      $fatal(1, "bench stopped");
   endtask

   // One clock: observe at negedge, update all inputs 1ns after posedge.
   task automatic step();
      logic [1:0] ar_hs;
      logic       s_hs, r_hs;
      @(negedge clk_i);
      ar_hs     = m_arvalid_i & m_arready_o;
      s_hs      = s_arvalid_o & s_arready_i;
      r_hs      = s_rvalid_i & s_rready_o;
      n_sarv    = s_arvalid_o;
      n_rhs     = r_hs;
      n_last_hs = r_hs & s_rlast_i;
      if (s_hs) begin
         sl_addr = s_araddr_o;
         sl_len  = s_arlen_o;
      end
      @(posedge clk_i);
      #1;
      m_arvalid_i = m_arvalid_i & ~ar_hs;
      if (ar_hs[0]) m0_grants++;
      if (m0_cont) m_arvalid_i[0] = 1'b1;
      if (n_sarv && ar_hold != 0) ar_hold--;
      s_arready_i = (ar_hold == 0);
      if (r_hs) begin
         if (s_rlast_i) s_rvalid_i = 1'b0;
         else sl_beat++;
      end
      if (s_hs) begin
         sl_beat    = 0;
         s_rvalid_i = 1'b1;
      end
      if (rst_i) begin
         s_rvalid_i = 1'b0;
         sl_beat    = 0;
      end
      s_rdata_i  = sl_addr + 32'(sl_beat);
      s_rresp_i  = 2'(sl_beat);
      s_rlast_i  = s_rvalid_i && (sl_beat == int'(sl_len));
      m_rready_i = rr_toggle ? ~m_rready_i : 2'b11;
   endtask

   task automatic wait_done(string name);
      int n = 0;
      while (!(busy_o == 1'b0 && m_arvalid_i == '0 && s_rvalid_i == 1'b0 &&
               ar_q.size() == 0 && r_q.size() == 0)) begin
         if (n == 200) timeout(name);
         step();
         n++;
      end
      step();
   endtask

   // Monitor / scoreboard.
   initial begin : monitor
      ar_exp_t ae;
      r_exp_t  re;
      st_exp_t se;
      forever begin
         @(negedge clk_i);
         if (done) begin
            chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
            chk("r_q_empty", 64'(r_q.size()), 64'd0);
            chk("st_q_empty", 64'(st_q.size()), 64'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         if (s_arvalid_o && s_arready_i) begin
            if (ar_q.size() == 0) begin
               chk("ar_unexpected", 64'(s_araddr_o), 64'd0 - 64'd1);
            end else begin
               ae = ar_q.pop_front();
               chk("ar_grant", 64'(grant_o), 64'(ae.master));
               chk("ar_addr", 64'(s_araddr_o), 64'(ae.addr));
               chk("ar_len", 64'(s_arlen_o), 64'(ae.len));
               chk("ar_mready", 64'(m_arready_o), 64'(onehot(ae.master)));
            end
         end
         if ((m_rvalid_o & m_rready_i) != '0) begin
            if (r_q.size() == 0) begin
               chk("r_unexpected", 64'(m_rvalid_o), 64'd0);
            end else begin
               re = r_q.pop_front();
               chk("r_valid", 64'(m_rvalid_o), 64'(onehot(re.master)));
               chk("r_data", 64'(m_rdata_o), 64'(re.data));
               chk("r_resp", 64'(m_rresp_o), 64'(re.resp));
               chk("r_last", 64'(m_rlast_o), 64'(re.last));
            end
         end
         if (st_q.size() != 0) begin
            se = st_q.pop_front();
            chk("st_busy", 64'(busy_o), 64'(se.busy));
            chk("st_sarvalid", 64'(s_arvalid_o), 64'(se.sarv));
            chk("st_saraddr", 64'(s_araddr_o), 64'(se.saddr));
            chk("st_marready", 64'(m_arready_o), 64'(se.mar));
            chk("st_mrvalid", 64'(m_rvalid_o), 64'(se.mrv));
            chk("st_srready", 64'(s_rready_o), 64'(se.srr));
            chk("st_grant", 64'(grant_o), 64'(se.grant));
            chk("st_rdata", 64'(m_rdata_o), 64'(se.rdata));
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "bench stopped");
   end

   initial begin : main
      int n;
      rst_i       = 1'b1;
      m_arvalid_i = '0;
      m_araddr_i  = '0;
      m_arlen_i   = '0;
      m_rready_i  = 2'b11;
      s_arready_i = 1'b1;
      s_rvalid_i  = 1'b0;
      s_rdata_i   = '0;
      s_rresp_i   = '0;
      s_rlast_i   = 1'b0;
      sl_addr = '0; sl_len = '0; sl_beat = 0; ar_hold = 0;
      rr_toggle = 1'b0; m0_cont = 1'b0; m0_grants = 0;
      n_sarv = 1'b0; n_rhs = 1'b0; n_last_hs = 1'b0;

      repeat (2) @(posedge clk_i);
      #1;
      expect_st(0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      step();
      rst_i = 1'b0;
      step();

      // Simultaneous requests: master 0 first, master 1 after master 0's last beat.
      expect_txn(0, 32'h0001_0000, 8'd1, 2);
      expect_txn(1, 32'h0002_0100, 8'd2, 3);
      issue(0, 32'h0001_0000, 8'd1);
      issue(1, 32'h0002_0100, 8'd2);
      wait_done("both_req");

      // Four beats to master 1 with toggling ready; idle the cycle after rlast.
      rr_toggle = 1'b1;
      expect_txn(1, 32'h0002_0000, 8'd3, 4);
      issue(1, 32'h0002_0000, 8'd3);
      n = 0;
      do begin
         step();
         if (++n > 60) timeout("burst_last");
      end while (!n_last_hs);
      expect_st(0, 0, 32'h0, 2'b00, 2'b00, 0, 1, 32'h0);
      rr_toggle = 1'b0;
      wait_done("burst");

      // Downstream AR stall: valid/address held, master ready low until handshake.
      ar_hold     = 5;
      s_arready_i = 1'b0;
      expect_txn(0, 32'h0001_2340, 8'd0, 1);
      issue(0, 32'h0001_2340, 8'd0);
      n = 0;
      do begin
         step();
         if (++n > 10) timeout("stall_start");
      end while (!n_sarv);
      for (int i = 0; i < 4; i++) begin
         expect_st(1, 1, 32'h0001_2340, 2'b00, 2'b00, 0, 0, 32'h0);
         step();
      end
      wait_done("stall");

`ifdef AXI_RD_ARB_DECERR_EN
      // Decode error answered locally: two DECERR beats, never forwarded.
      expect_err(1, 8'd1);
      issue(1, 32'h0003_0000, 8'd1);
      step();
      expect_st(1, 0, 32'h0003_0000, 2'b10, 2'b00, 0, 1, 32'h0);
      wait_done("decerr");
`else
      // Decode error flag ignored: request forwarded normally.
      expect_txn(1, 32'h0003_0000, 8'd1, 2);
      issue(1, 32'h0003_0000, 8'd1);
      wait_done("decerr_off");
`endif

      // Master 0 requests continuously, master 1 once: order m0, m1, m0.
      expect_txn(0, 32'h0000_1000, 8'd1, 2);
      expect_txn(1, 32'h0002_2000, 8'd0, 1);
      expect_txn(0, 32'h0000_1000, 8'd1, 2);
      m0_grants = 0;
      m0_cont   = 1'b1;
      issue(0, 32'h0000_1000, 8'd1);
      n = 0;
      while (m0_grants < 1) begin
         step();
         if (++n > 20) timeout("starve_first");
      end
      issue(1, 32'h0002_2000, 8'd0);
      while (m0_grants < 2) begin
         step();
         if (++n > 100) timeout("starve_second");
      end
      m0_cont        = 1'b0;
      m_arvalid_i[0] = 1'b0;
      wait_done("starve");

      // Reset on the second beat: everything drops at once, master 0 wins afterwards.
      expect_txn(0, 32'h0004_0000, 8'd3, 1);
      issue(0, 32'h0004_0000, 8'd3);
      n = 0;
      do begin
         step();
         if (++n > 20) timeout("rst_beat");
      end while (!n_rhs);
      rst_i = 1'b1;
      #1;
      expect_st(0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 32'h0);
      step();
      rst_i = 1'b0;
      expect_txn(0, 32'h0005_0000, 8'd0, 1);
      expect_txn(1, 32'h0006_0000, 8'd0, 1);
      issue(0, 32'h0005_0000, 8'd0);
      issue(1, 32'h0006_0000, 8'd0);
      wait_done("after_rst");

      done = 1'b1;
   end

endmodule
